// File: rtl/micro_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : micro_seq_pkg
//  Purpose  : Shared types and default sizes for the microprogram sequencer.
//             Provides the 3-bit sequencer opcode enumeration and the default
//             microaddress width / return-stack depth.
//  Revision : 1.0 - initial release
// ============================================================================
package micro_seq_pkg;

    localparam int unsigned AW_DEF    = 8;
    localparam int unsigned DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        JZ   = 3'd0,   // jump to zero, clear stack
        CJS  = 3'd1,   // conditional jump to subroutine
        CJP  = 3'd2,   // conditional jump
        PUSH = 3'd3,   // push micro-PC, conditional counter load
        RPCT = 3'd4,   // repeat at d while counter non-zero
        CRTN = 3'd5,   // conditional return
        RFCT = 3'd6,   // repeat loop from stack while counter non-zero
        CONT = 3'd7    // continue
    } opcode_t;

endpackage : micro_seq_pkg
`default_nettype wire

// File: rtl/micro_stack.sv
`default_nettype none
// ============================================================================
//  Module   : micro_stack
//  Purpose  : Small LIFO return stack for the microprogram sequencer.
//             A push onto a full stack overwrites the top entry; a pop from an
//             empty stack does nothing. Clear resets the pointer only.
//  Ports    : clk_i, rst_i (async, active-high)
//             push_i, pop_i, clr_i : stack operations (clear has priority)
//             din_i  [AW]          : value to push
//             tos_o  [AW]          : top-of-stack, 0 when empty
//             full_o, empty_o      : occupancy flags
//  Revision : 1.0 - initial release
// ============================================================================
module micro_stack #(
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clr_i,
    input  logic [AW-1:0] din_i,
    output logic [AW-1:0] tos_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned SPW = $clog2(DEPTH + 1);
    localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SPW-1:0] sp_q;
    logic [AW-1:0]  stk_q [DEPTH];

    logic [IW-1:0]  w_top_idx;

    assign full_o    = (sp_q == SPW'(DEPTH));
    assign empty_o   = (sp_q == '0);
    assign w_top_idx = IW'(sp_q - 1'b1);
    assign tos_o     = empty_o ? '0 : stk_q[w_top_idx];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sp_q <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                stk_q[k] <= '0;
            end
        end else if (clr_i) begin
            sp_q <= '0;
        end else if (push_i) begin
            if (full_o) begin
                // Saturated: replace the newest entry instead of growing.
                stk_q[DEPTH-1] <= din_i;
            end else begin
                stk_q[sp_q[IW-1:0]] <= din_i;
                sp_q                <= sp_q + 1'b1;
            end
        end else if (pop_i && !empty_o) begin
            sp_q <= sp_q - 1'b1;
        end
    end

endmodule : micro_stack
`default_nettype wire

// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : micro_sequencer
//  Purpose  : Am2910-style microprogram sequencer. Produces the next
//             microaddress y every cycle from the micro-PC, the branch input
//             d, a loadable down-counter R and a LIFO return stack.
//  Ports    : cp (clock), reset (async, active-high)
//             i [3]      : opcode            cc_n, ccen_n : condition test
//             rld_n      : load R from d     ci           : micro-PC carry-in
//             d [AW]     : branch address / counter value
//             y [AW]     : next microaddress (combinational)
//             full_n, empty_n : stack occupancy (active-low)
//  Revision : 1.0 - initial release
// ============================================================================
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic          cp,
    input  logic          reset,
    input  logic [2:0]    i,
    input  logic          cc_n,
    input  logic          ccen_n,
    input  logic          rld_n,
    input  logic          ci,
    input  logic [AW-1:0] d,
    output logic [AW-1:0] y,
    output logic          full_n,
    output logic          empty_n
);

    localparam logic [AW-1:0] c_one = AW'(1);

    logic [AW-1:0] upc_q, upc_d;
    logic [AW-1:0] r_q, r_d;

    logic          w_pass;
    logic          w_r_nz;
    logic          w_push;
    logic          w_pop;
    logic          w_clr;
    logic [AW-1:0] w_tos;
    logic          w_full;
    logic          w_empty;

    assign w_pass = ccen_n | ~cc_n;
    assign w_r_nz = |r_q;

    always_comb begin
        y      = upc_q;
        r_d    = r_q;
        w_push = 1'b0;
        w_pop  = 1'b0;
        w_clr  = 1'b0;
        unique case (opcode_t'(i))
            JZ: begin
                y     = '0;
                w_clr = 1'b1;
            end
            CJS: begin
                if (w_pass) begin
                    y      = d;
                    w_push = 1'b1;
                end
            end
            CJP: begin
                if (w_pass) y = d;
            end
            PUSH: begin
                w_push = 1'b1;
                if (w_pass) r_d = d;
            end
            RPCT: begin
                if (w_r_nz) begin
                    y   = d;
                    r_d = r_q - c_one;
                end
            end
            CRTN: begin
                if (w_pass) begin
                    y     = w_tos;
                    w_pop = 1'b1;
                end
            end
            RFCT: begin
                // Loop back to the stacked address; the entry is only
                // discarded once the count is exhausted.
                if (w_r_nz) begin
                    y   = w_tos;
                    r_d = r_q - c_one;
                end else begin
                    w_pop = 1'b1;
                end
            end
            CONT: begin
                y = upc_q;
            end
            default: begin
                y = upc_q;
            end
        endcase
        // An explicit load beats both the decrement and the PUSH load.
        if (!rld_n) r_d = d;
    end

    assign upc_d   = y + {{(AW-1){1'b0}}, ci};
    assign full_n  = ~w_full;
    assign empty_n = ~w_empty;

    always_ff @(posedge cp or posedge reset) begin
        if (reset) begin
            upc_q <= '0;
            r_q   <= '0;
        end else begin
            upc_q <= upc_d;
            r_q   <= r_d;
        end
    end

    // Push value is the pre-edge micro-PC.
    micro_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk_i   (cp),
        .rst_i   (reset),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .clr_i   (w_clr),
        .din_i   (upc_q),
        .tos_o   (w_tos),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

endmodule : micro_sequencer
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_micro_sequencer
//  Purpose  : Directed self-checking bench for micro_sequencer (AW=8, DEPTH=4).
//             Inputs change on the falling edge; y and the flags are sampled
//             1 time unit later, well away from the rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_micro_sequencer;

    localparam logic [2:0] OP_JZ   = 3'd0;
    localparam logic [2:0] OP_CJS  = 3'd1;
    localparam logic [2:0] OP_CJP  = 3'd2;
    localparam logic [2:0] OP_PUSH = 3'd3;
    localparam logic [2:0] OP_RPCT = 3'd4;
    localparam logic [2:0] OP_CRTN = 3'd5;
    localparam logic [2:0] OP_RFCT = 3'd6;
    localparam logic [2:0] OP_CONT = 3'd7;

    logic       cp;
    logic       reset;
    logic [2:0] i;
    logic       cc_n;
    logic       ccen_n;
    logic       rld_n;
    logic       ci;
    logic [7:0] d;
    logic [7:0] y;
    logic       full_n;
    logic       empty_n;

    int n_checks;
    int n_errors;

    micro_sequencer #(
        .AW    (8),
        .DEPTH (4)
    ) dut (
        .cp      (cp),
        .reset   (reset),
        .i       (i),
        .cc_n    (cc_n),
        .ccen_n  (ccen_n),
        .rld_n   (rld_n),
        .ci      (ci),
        .d       (d),
        .y       (y),
        .full_n  (full_n),
        .empty_n (empty_n)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait for the falling edge, apply one cycle of inputs, let y settle.
    task automatic cyc(input logic [2:0] op, input logic ccn, input logic ccen,
                       input logic rld, input logic c, input logic [7:0] dv);
        @(negedge cp);
        i      = op;
        cc_n   = ccn;
        ccen_n = ccen;
        rld_n  = rld;
        ci     = c;
        d      = dv;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset  = 1'b1;
        i      = OP_CONT;
        cc_n   = 1'b1;
        ccen_n = 1'b1;
        rld_n  = 1'b1;
        ci     = 1'b1;
        d      = 8'h00;

        // ---------------- reset state and continue ----------------
        @(negedge cp);
        #1;
        chk("rst_y", 32'(y), 32'h0);
        chk("rst_full_n", 32'(full_n), 32'h1);
        chk("rst_empty_n", 32'(empty_n), 32'h0);
        reset = 1'b0;
        cyc(OP_CONT, 1, 1, 1, 1, 8'h00); chk("cont_y1", 32'(y), 32'h1);
        cyc(OP_CONT, 1, 1, 1, 1, 8'h00); chk("cont_y2", 32'(y), 32'h2);
        cyc(OP_CONT, 1, 1, 1, 1, 8'h00); chk("cont_y3", 32'(y), 32'h3);

        // asynchronous reset in the middle of a cycle
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_y", 32'(y), 32'h0);
        @(negedge cp);
        reset = 1'b0;
        #1;
        chk("rel_y0", 32'(y), 32'h0);
        chk("rel_empty_n", 32'(empty_n), 32'h0);
        cyc(OP_CONT, 1, 1, 1, 1, 8'h00); chk("rel_y1", 32'(y), 32'h1);
        cyc(OP_CONT, 1, 1, 1, 1, 8'h00); chk("rel_y2", 32'(y), 32'h2);

        // ---------------- conditional jump (upc = 3) ----------------
        cyc(OP_CJP, 1, 0, 1, 1, 8'h40); chk("cjp_fail", 32'(y), 32'h3);
        cyc(OP_CJP, 0, 0, 1, 1, 8'h40); chk("cjp_pass", 32'(y), 32'h40);
        cyc(OP_CONT, 1, 1, 1, 1, 8'h00); chk("cjp_next", 32'(y), 32'h41);

        // ---------------- call and return ----------------
        cyc(OP_CJP, 1, 1, 1, 1, 8'h04); chk("to_04", 32'(y), 32'h04);
        cyc(OP_CJS, 0, 0, 1, 1, 8'h80); chk("cjs_y", 32'(y), 32'h80);
        chk("cjs_empty_n_pre", 32'(empty_n), 32'h0);
        cyc(OP_CONT, 1, 1, 1, 1, 8'h00); chk("sub_y", 32'(y), 32'h81);
        chk("call_empty_n", 32'(empty_n), 32'h1);
        cyc(OP_CRTN, 1, 0, 1, 1, 8'h00); chk("crtn_fail", 32'(y), 32'h82);
        cyc(OP_CRTN, 1, 1, 1, 1, 8'h00); chk("crtn_y", 32'(y), 32'h05);
        cyc(OP_CONT, 1, 1, 1, 1, 8'h00); chk("ret_y", 32'(y), 32'h06);
        chk("ret_empty_n", 32'(empty_n), 32'h0);

        // ---------------- counted loop ----------------
        cyc(OP_CJP, 1, 1, 1, 1, 8'h0F); chk("to_0f", 32'(y), 32'h0F);
        cyc(OP_PUSH, 1, 1, 1, 1, 8'h02); chk("push_y", 32'(y), 32'h10);
        cyc(OP_CONT, 1, 1, 1, 1, 8'h00); chk("body1", 32'(y), 32'h11);
        cyc(OP_RFCT, 1, 1, 1, 1, 8'h00); chk("rfct1", 32'(y), 32'h10);
        cyc(OP_CONT, 1, 1, 1, 1, 8'h00); chk("body2", 32'(y), 32'h11);
        cyc(OP_RFCT, 1, 1, 1, 1, 8'h00); chk("rfct2", 32'(y), 32'h10);
        cyc(OP_CONT, 1, 1, 1, 1, 8'h00); chk("body3", 32'(y), 32'h11);
        chk("loop_empty_n", 32'(empty_n), 32'h1);
        cyc(OP_RFCT, 1, 1, 1, 1, 8'h00); chk("rfct_exit", 32'(y), 32'h12);
        cyc(OP_CONT, 1, 1, 1, 1, 8'h00); chk("exit_y", 32'(y), 32'h13);
        chk("exit_empty_n", 32'(empty_n), 32'h0);

        // ---------------- stack full / empty edges (upc = 0x14) -------
        // failing PUSH condition: push still happens, R is not loaded
        for (int k = 0; k < 5; k++) begin
            cyc(OP_PUSH, 1, 0, 1, 1, 8'hAA);
            chk("push_full_n", 32'(full_n), (k == 4) ? 32'h0 : 32'h1);
            chk("push_seq_y", 32'(y), 32'h14 + 32'(k));
        end
        cyc(OP_CRTN, 1, 0, 1, 1, 8'h00); chk("full_crtn_fail", 32'(y), 32'h19);
        chk("full_flag", 32'(full_n), 32'h0);
        cyc(OP_CRTN, 1, 1, 1, 1, 8'h00); chk("pop1", 32'(y), 32'h18);
        cyc(OP_CRTN, 1, 1, 1, 1, 8'h00); chk("pop2", 32'(y), 32'h16);
        chk("pop2_full_n", 32'(full_n), 32'h1);
        cyc(OP_CRTN, 1, 1, 1, 1, 8'h00); chk("pop3", 32'(y), 32'h15);
        cyc(OP_CRTN, 1, 1, 1, 1, 8'h00); chk("pop4", 32'(y), 32'h14);
        cyc(OP_CRTN, 1, 1, 1, 1, 8'h00); chk("pop5_y", 32'(y), 32'h00);
        chk("pop5_empty_n", 32'(empty_n), 32'h0);
        cyc(OP_CONT, 1, 1, 1, 1, 8'h00); chk("after_pop5", 32'(y), 32'h01);
        chk("still_empty", 32'(empty_n), 32'h0);

        // ---------------- repeat, counter load, wrap (upc = 2, r = 0) ----
        cyc(OP_RPCT, 1, 1, 1, 1, 8'h30); chk("rpct_r0", 32'(y), 32'h02);
        cyc(OP_CONT, 1, 1, 0, 1, 8'h01); chk("rld_cont", 32'(y), 32'h03);
        cyc(OP_RPCT, 1, 1, 0, 1, 8'h03); chk("rpct_rld", 32'(y), 32'h03);
        cyc(OP_RPCT, 1, 1, 1, 1, 8'h50); chk("rpct3", 32'(y), 32'h50);
        cyc(OP_RPCT, 1, 1, 1, 1, 8'h50); chk("rpct2", 32'(y), 32'h50);
        cyc(OP_RPCT, 1, 1, 1, 1, 8'h50); chk("rpct1", 32'(y), 32'h50);
        cyc(OP_RPCT, 1, 1, 1, 1, 8'h50); chk("rpct_done", 32'(y), 32'h51);
        cyc(OP_CJP, 1, 1, 1, 1, 8'hFE); chk("to_fe", 32'(y), 32'hFE);
        cyc(OP_CONT, 1, 1, 1, 1, 8'h00); chk("at_ff", 32'(y), 32'hFF);
        cyc(OP_CONT, 1, 1, 1, 1, 8'h00); chk("wrap", 32'(y), 32'h00);
        cyc(OP_CONT, 1, 1, 1, 0, 8'h00); chk("ci0_a", 32'(y), 32'h01);
        cyc(OP_CONT, 1, 1, 1, 1, 8'h00); chk("ci0_b", 32'(y), 32'h01);

        // ---------------- JZ clears the stack ----------------
        cyc(OP_CJS, 1, 1, 1, 1, 8'h20); chk("jz_call", 32'(y), 32'h20);
        cyc(OP_CONT, 1, 1, 1, 1, 8'h00); chk("jz_pre_empty_n", 32'(empty_n), 32'h1);
        cyc(OP_JZ, 1, 1, 1, 1, 8'h77); chk("jz_y", 32'(y), 32'h00);
        cyc(OP_CONT, 1, 1, 1, 1, 8'h00); chk("jz_post_y", 32'(y), 32'h01);
        chk("jz_empty_n", 32'(empty_n), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_micro_sequencer
`default_nettype wire
